// File: rtl/warp_rr_arbiter.sv
// warp_rr_arbiter: N-way round-robin ready/valid arbiter with a registered output stage.
// Define WARP_ARB_LOCK_EN to let a requester hold exclusive ownership via i_req_lock.
module warp_rr_arbiter #(
  parameter int N = 4,
  parameter int WIDTH = 32,
  parameter int SRCW = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N-1:0]       i_req_valid,
  output logic [N-1:0]       o_req_ready,
  input  logic [N*WIDTH-1:0] i_req_data,
  input  logic [N-1:0]       i_req_lock,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_out_data,
  output logic [SRCW-1:0]    o_out_src
);
  logic [SRCW-1:0]  r_ptr;
  logic [SRCW-1:0]  w_sel;
  logic [N-1:0]     w_elig;
  logic             w_any;
  logic             w_can_accept;
  logic             w_accept;
  logic [WIDTH-1:0] w_pay [N];

  for (genvar k = 0; k < N; k++) begin : g_pay
    assign w_pay[k] = i_req_data[k*WIDTH +: WIDTH];
  end

`ifdef WARP_ARB_LOCK_EN
  logic            r_lock_active;
  logic [SRCW-1:0] r_lock_idx;
  assign w_elig = r_lock_active ? i_req_valid & (N'(1) << r_lock_idx) : i_req_valid;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_active <= 1'b0;
      r_lock_idx    <= '0;
    end else if (w_accept) begin
      r_lock_active <= i_req_lock[w_sel];
      r_lock_idx    <= w_sel;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^i_req_lock;
  assign w_elig = i_req_valid;
`endif

  // Scan from highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_elig[SRCW'((int'(r_ptr) + i) % N)]) begin
        w_sel = SRCW'((int'(r_ptr) + i) % N);
        w_any = 1'b1;
      end
    end
  end

  assign w_can_accept = !o_out_valid || i_out_ready;
  assign w_accept     = i_rst_n && w_any && w_can_accept;
  assign o_req_ready  = w_accept ? N'(1) << w_sel : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_src   <= '0;
    end else if (w_accept) begin
      r_ptr       <= (w_sel == SRCW'(N - 1)) ? '0 : w_sel + 1'b1;
      o_out_valid <= 1'b1;
      o_out_data  <= w_pay[w_sel];
      o_out_src   <= w_sel;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_warp_rr_arbiter.sv
// tb_warp_rr_arbiter: randomized and directed checks of warp_rr_arbiter against a queue-free behavioural model.
module tb_warp_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid = '0;
  logic [3:0]  ready;
  logic [127:0] data = '0;
  logic [3:0]  lock = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic [2:0]  valid3 = '0;
  logic [2:0]  ready3;
  logic [95:0] data3 = '0;
  logic [2:0]  lock3 = '0;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [31:0] out_data3;
  logic [1:0]  out_src3;

  int checks = 0;
  int failures = 0;

  int          m_ptr;
  bit          m_val;
  logic [31:0] m_data;
  int          m_src;
  bit          m_lock_act;
  int          m_lock_idx;
`ifdef WARP_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  warp_rr_arbiter #(.N(4), .WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_data(data), .i_req_lock(lock), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_src(out_src)
  );

  warp_rr_arbiter #(.N(3), .WIDTH(32)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid3), .o_req_ready(ready3),
    .i_req_data(data3), .i_req_lock(lock3), .o_out_valid(out_valid3),
    .i_out_ready(out_ready3), .o_out_data(out_data3), .o_out_src(out_src3)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_ptr = 0; m_val = 0; m_data = 0; m_src = 0; m_lock_act = 0; m_lock_idx = 0;
  endtask

  function automatic int m_sel();
    for (int off = 0; off < 4; off++) begin
      int k = (m_ptr + off) % 4;
      if (valid[k] && (!m_lock_act || k == m_lock_idx)) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int s = m_sel();
    return (s >= 0 && (!m_val || out_ready)) ? 4'(1 << s) : 4'b0;
  endfunction

  task automatic m_clock();
    int s = m_sel();
    if (s >= 0 && (!m_val || out_ready)) begin
      m_data = data[s*32 +: 32];
      m_src  = s;
      m_val  = 1;
      m_ptr  = (s + 1) % 4;
      if (LOCK_EN) begin m_lock_act = lock[s]; m_lock_idx = s; end
    end else if (m_val && out_ready) m_val = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    valid = 4'hF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", out_data); end
    checks++; if (out_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d want=0", out_src); end
    checks++; if (ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b want=0000", ready); end
    @(negedge clk);
    valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    int exp_src [5] = '{0, 1, 2, 3, 0};
    @(negedge clk);
    for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'h10 + k;
    valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ready !== 4'(1 << exp_src[c])) begin failures++; $display("FAIL rot_ready c=%0d got=%b want=%b", c, ready, 4'(1 << exp_src[c])); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_src !== 2'(exp_src[c])) begin failures++; $display("FAIL rot_src c=%0d got=%b/%0d want=1/%0d", c, out_valid, out_src, exp_src[c]); end
      checks++; if (out_data !== 32'h10 + exp_src[c]) begin failures++; $display("FAIL rot_data c=%0d got=%h want=%h", c, out_data, 32'h10 + exp_src[c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] vpat [3] = '{4'b0100, 4'b0100, 4'b0101};
    int exp_src [3] = '{2, 2, 0};
    for (int c = 0; c < 3; c++) begin
      valid = vpat[c];
      tick();
      checks++; if (out_src !== 2'(exp_src[c]) || out_valid !== 1'b1) begin failures++; $display("FAIL wrap c=%0d got=%0d want=%0d", c, out_src, exp_src[c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    valid = 4'b0010; data[32 +: 32] = 32'hAA; out_ready = 1'b1;
    tick();
    @(negedge clk);
    valid = 4'b1101; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (ready !== 4'b0) begin failures++; $display("FAIL stall_ready c=%0d got=%b want=0000", c, ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hAA || out_src !== 2'd1) begin failures++; $display("FAIL stall_hold c=%0d got=%b/%h/%0d want=1/aa/1", c, out_valid, out_data, out_src); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (ready !== 4'b0100) begin failures++; $display("FAIL stall_release got=%b want=0100", ready); end
    tick();
    checks++; if (out_src !== 2'd2 || out_data !== 32'h12) begin failures++; $display("FAIL stall_next got=%0d/%h want=2/12", out_src, out_data); end
    @(negedge clk);
    valid = '0;
    tick();
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      valid = 4'($urandom);
      lock = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) data[k*32 +: 32] = $urandom;
      #1;
      checks++; if (ready !== m_ready()) begin failures++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, ready, m_ready()); end
      tick();
      checks++; if (out_valid !== m_val || out_data !== m_data || out_src !== 2'(m_src)) begin failures++; $display("FAIL rand_out c=%0d got=%b/%h/%0d want=%b/%h/%0d", c, out_valid, out_data, out_src, m_val, m_data, m_src); end
      @(negedge clk);
    end
    lock = '0;
  endtask

  task automatic test_reset_mid();
    valid = 4'hF; out_ready = 1'b1;
    tick();
    @(negedge clk);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b want=1", out_valid); end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || ready !== 4'b0) begin failures++; $display("FAIL mid_drop got=%b/%b want=0/0000", out_valid, ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ready !== 4'b0001) begin failures++; $display("FAIL mid_first_ready got=%b want=0001", ready); end
    tick();
    checks++; if (out_src !== 2'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_first got=%0d want=0", out_src); end
    @(negedge clk);
  endtask

  task automatic test_lock();
    int beats = 0;
`ifdef WARP_ARB_LOCK_EN
    int exp_src [4] = '{1, 1, 1, 2};
`else
    int exp_src [4] = '{1, 2, 3, 0};
`endif
    valid = '0;
    tick();
    @(negedge clk);
    checks++; if (m_ptr != 1) begin failures++; $display("FAIL lock_setup model ptr=%0d want=1", m_ptr); end
    valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      lock = {2'b0, beats < 2, 1'b0};
      data[32 +: 32] = 32'hB0 + beats;
      #1;
      checks++; if (ready !== 4'(1 << exp_src[c])) begin failures++; $display("FAIL lock_ready c=%0d got=%b want=%b", c, ready, 4'(1 << exp_src[c])); end
      if (ready[1]) beats++;
      tick();
      checks++; if (out_src !== 2'(exp_src[c]) || out_src !== 2'(m_src)) begin failures++; $display("FAIL lock_src c=%0d got=%0d want=%0d", c, out_src, exp_src[c]); end
      @(negedge clk);
    end
    valid = '0; lock = '0;
    tick();
    @(negedge clk);
  endtask

  task automatic test_n3();
    int exp_src [4] = '{0, 1, 2, 0};
    for (int k = 0; k < 3; k++) data3[k*32 +: 32] = 32'h30 + k;
    valid3 = 3'b111; out_ready3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checks++; if (out_src3 !== 2'(exp_src[c]) || out_data3 !== 32'h30 + exp_src[c] || out_valid3 !== 1'b1) begin failures++; $display("FAIL n3 c=%0d got=%0d/%h want=%0d", c, out_src3, out_data3, exp_src[c]); end
      @(negedge clk);
    end
    valid3 = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_stall();
    test_random();
    test_reset_mid();
    test_lock();
    test_n3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
